// File: rtl/led_pattern_engine.sv
// led_pattern_engine: stepped LED patterns (bounce, rotate up/down, bar fill) with PWM dimming.
// Ports: Clock, Reset_n, Mode, Pause, Brightness -> Leds, Step_pulse, Position.
module led_pattern_engine #(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int NUM_LEDS        = 6,
  parameter int STEP_MS         = 100,
  parameter int PWM_BITS        = 4,
  parameter bit ACTIVE_LOW      = 1
) (
  input  logic                            Clock,
  input  logic                            Reset_n,
  input  logic [1:0]                      Mode,
  input  logic                            Pause,
  input  logic [PWM_BITS-1:0]             Brightness,
  output logic [NUM_LEDS-1:0]             Leds,
  output logic                            Step_pulse,
  output logic [$clog2(NUM_LEDS+1)-1:0]   Position
);

  localparam int STEP_TICKS = (CLOCK_FREQUENCY / 1000) * STEP_MS;
  localparam int CW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int PW = $clog2(NUM_LEDS + 1);

  localparam logic [1:0] M_BOUNCE = 2'b00;
  localparam logic [1:0] M_UP     = 2'b01;
  localparam logic [1:0] M_DOWN   = 2'b10;
  localparam logic [1:0] M_FILL   = 2'b11;

  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_TICKS - 1);
  localparam logic [PW-1:0] POS_TOP   = PW'(NUM_LEDS - 1);
  localparam logic [PW-1:0] LVL_TOP   = PW'(NUM_LEDS);
  localparam logic [PW-1:0] PW_ONE    = PW'(1);

  logic [CW-1:0]       step_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [1:0]          cur_mode;
  logic [NUM_LEDS-1:0] pattern;
  logic                dir;
  // Lit index in the one-hot modes, fill level in bar-fill mode.
  logic [PW-1:0]       pos;

  logic                tick;
  logic                on;
  logic [NUM_LEDS-1:0] lit;
  logic [NUM_LEDS-1:0] pattern_nxt;
  logic [PW-1:0]       pos_nxt;
  logic                dir_nxt;

  assign tick     = (step_cnt == STEP_LAST) && !Pause;
  assign on       = (&Brightness) || (pwm_cnt < Brightness);
  assign lit      = pattern & {NUM_LEDS{on}};
  assign Position = pos;

  always_comb begin
    pattern_nxt = pattern;
    pos_nxt     = pos;
    dir_nxt     = dir;
    if (Mode != cur_mode) begin
      dir_nxt     = 1'b1;
      pos_nxt     = '0;
      pattern_nxt = (Mode == M_FILL) ? '0 : NUM_LEDS'(1);
    end else begin
      unique case (cur_mode)
        M_BOUNCE: begin
          // Reverse on reaching an end so the end LED is shown once.
          if (dir) begin
            if (pos == POS_TOP) begin
              dir_nxt     = 1'b0;
              pattern_nxt = pattern >> 1;
              pos_nxt     = pos - PW_ONE;
            end else begin
              pattern_nxt = pattern << 1;
              pos_nxt     = pos + PW_ONE;
            end
          end else begin
            if (pos == '0) begin
              dir_nxt     = 1'b1;
              pattern_nxt = pattern << 1;
              pos_nxt     = pos + PW_ONE;
            end else begin
              pattern_nxt = pattern >> 1;
              pos_nxt     = pos - PW_ONE;
            end
          end
        end
        M_UP: begin
          pattern_nxt = {pattern[NUM_LEDS-2:0], pattern[NUM_LEDS-1]};
          pos_nxt     = (pos == POS_TOP) ? '0 : pos + PW_ONE;
        end
        M_DOWN: begin
          pattern_nxt = {pattern[0], pattern[NUM_LEDS-1:1]};
          pos_nxt     = (pos == '0) ? POS_TOP : pos - PW_ONE;
        end
        M_FILL: begin
          pos_nxt = (pos == LVL_TOP) ? '0 : pos + PW_ONE;
          for (int i = 0; i < NUM_LEDS; i++) begin
            pattern_nxt[i] = (PW'(i) < pos_nxt);
          end
        end
        default: begin
          pattern_nxt = pattern;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      step_cnt   <= '0;
      pwm_cnt    <= '0;
      Step_pulse <= 1'b0;
      Leds       <= {NUM_LEDS{ACTIVE_LOW}};
    end else begin
      pwm_cnt    <= pwm_cnt + PWM_BITS'(1);
      Step_pulse <= tick;
      Leds       <= lit ^ {NUM_LEDS{ACTIVE_LOW}};
      if (!Pause) begin
        step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cur_mode <= M_BOUNCE;
      pattern  <= NUM_LEDS'(1);
      dir      <= 1'b1;
      pos      <= '0;
    end else if (tick) begin
      cur_mode <= Mode;
      pattern  <= pattern_nxt;
      dir      <= dir_nxt;
      pos      <= pos_nxt;
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb_led_pattern_engine: vector table plus scoreboard for led_pattern_engine.
// 4 LEDs, 4-cycle step, 4-bit PWM, active-low pins.
module tb_led_pattern_engine;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic [1:0] Mode;
  logic       Pause;
  logic [3:0] Brightness;
  logic [3:0] Leds;
  logic       Step_pulse;
  logic [2:0] Position;

  led_pattern_engine #(
    .CLOCK_FREQUENCY(1000),
    .NUM_LEDS(4),
    .STEP_MS(4),
    .PWM_BITS(4),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .Clock(Clock),
    .Reset_n(Reset_n),
    .Mode(Mode),
    .Pause(Pause),
    .Brightness(Brightness),
    .Leds(Leds),
    .Step_pulse(Step_pulse),
    .Position(Position)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [1:0] mode;
    logic [3:0] pat;
    logic [2:0] pos;
    int         gap;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  vec_t mon_e;

  int checks = 0;
  int failures = 0;
  int edges = 0;
  int last_edge = 0;
  logic       led_pend = 1'b0;
  logic [3:0] led_exp = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] m, input logic [3:0] p,
                              input logic [2:0] q, input int g);
    vec_t v;
    v.mode = m;
    v.pat  = p;
    v.pos  = q;
    v.gap  = g;
    return v;
  endfunction

  always @(posedge Clock) edges++;

  // Scoreboard: each Step_pulse pops one expected step.
  always @(negedge Clock) begin
    if (led_pend) begin
      chk("leds_after_step", Leds, 4'(~led_exp));
      chk("pulse_width", Step_pulse, 0);
      led_pend = 1'b0;
    end
    if (Step_pulse) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got pulse at Position=%0d, required none",
                 Position);
      end else begin
        mon_e = exp_q.pop_front();
        chk("position", Position, mon_e.pos);
        if (mon_e.gap > 0) chk("step_gap", edges - last_edge, mon_e.gap);
        led_exp  = mon_e.pat;
        led_pend = 1'b1;
      end
      last_edge = edges;
    end
  end

  task automatic wait_pulse(input string name, input int budget,
                            output int n);
    bit found;
    found = 0;
    n = 0;
    for (int i = 1; i <= budget && !found; i++) begin
      @(negedge Clock);
      if (Step_pulse) begin
        found = 1;
        n = i;
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL %s: no Step_pulse within %0d cycles, required one",
               name, budget);
    end
  endtask

  task automatic run_step(input vec_t v);
    int n;
    Mode = v.mode;
    exp_q.push_back(v);
    wait_pulse("step_timeout", 12, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation ran past time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    int bad;
    logic [3:0] snap;
    logic [3:0] blev[4];

    tbl.push_back(mk(2'd0, 4'b0100, 3'd2, 4));
    tbl.push_back(mk(2'd0, 4'b1000, 3'd3, 4));
    tbl.push_back(mk(2'd0, 4'b0100, 3'd2, 4));
    tbl.push_back(mk(2'd0, 4'b0010, 3'd1, 4));
    tbl.push_back(mk(2'd0, 4'b0001, 3'd0, 4));
    tbl.push_back(mk(2'd0, 4'b0010, 3'd1, 4));
    tbl.push_back(mk(2'd1, 4'b0001, 3'd0, 4));
    tbl.push_back(mk(2'd1, 4'b0010, 3'd1, 4));
    tbl.push_back(mk(2'd1, 4'b0100, 3'd2, 4));
    tbl.push_back(mk(2'd1, 4'b1000, 3'd3, 4));
    tbl.push_back(mk(2'd1, 4'b0001, 3'd0, 4));
    tbl.push_back(mk(2'd2, 4'b0001, 3'd0, 4));
    tbl.push_back(mk(2'd2, 4'b1000, 3'd3, 4));
    tbl.push_back(mk(2'd2, 4'b0100, 3'd2, 4));
    tbl.push_back(mk(2'd2, 4'b0010, 3'd1, 4));
    tbl.push_back(mk(2'd3, 4'b0000, 3'd0, 4));
    tbl.push_back(mk(2'd3, 4'b0001, 3'd1, 4));
    tbl.push_back(mk(2'd3, 4'b0011, 3'd2, 4));
    tbl.push_back(mk(2'd3, 4'b0111, 3'd3, 4));
    tbl.push_back(mk(2'd3, 4'b1111, 3'd4, 4));
    tbl.push_back(mk(2'd3, 4'b0000, 3'd0, 4));
    tbl.push_back(mk(2'd3, 4'b0001, 3'd1, 4));
    tbl.push_back(mk(2'd0, 4'b0001, 3'd0, 4));
    tbl.push_back(mk(2'd0, 4'b0010, 3'd1, 4));
    tbl.push_back(mk(2'd0, 4'b0100, 3'd2, 4));
    tbl.push_back(mk(2'd3, 4'b0000, 3'd0, 4));
    tbl.push_back(mk(2'd3, 4'b0001, 3'd1, 4));

    Reset_n    = 1'b1;
    Mode       = 2'd0;
    Pause      = 1'b0;
    Brightness = 4'hF;

    // Async reset before any clock edge.
    #2 Reset_n = 1'b0;
    #1;
    chk("reset_leds", Leds, 4'b1111);
    chk("reset_pulse", Step_pulse, 0);
    chk("reset_position", Position, 0);
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;
    exp_q.push_back(mk(2'd0, 4'b0010, 3'd1, 0));
    wait_pulse("first_step", 10, n);
    chk("first_step_latency", n, 4);

    // Reset asserted mid-step, between edges.
    @(negedge Clock);
    @(posedge Clock);
    #2;
    chk("leds_before_reset", Leds, 4'b1101);
    Reset_n = 1'b0;
    #1;
    chk("midreset_leds", Leds, 4'b1111);
    chk("midreset_pulse", Step_pulse, 0);
    chk("midreset_position", Position, 0);
    @(negedge Clock);
    Reset_n = 1'b1;
    exp_q.push_back(mk(2'd0, 4'b0010, 3'd1, 0));
    wait_pulse("step_after_reset", 10, n);
    chk("reset_step_latency", n, 4);

    foreach (tbl[i]) run_step(tbl[i]);

    // Pause at step_cnt=2 for 10 cycles.
    exp_q.push_back(mk(2'd3, 4'b0011, 3'd2, 14));
    repeat (2) @(negedge Clock);
    Pause = 1'b1;
    snap = Leds;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      chk("no_tick_paused", Step_pulse, 0);
    end
    chk("held_leds", Leds, snap);
    Pause = 1'b0;
    wait_pulse("resume_step", 6, n);
    chk("resume_latency", n, 2);

    // Pause held at terminal count.
    exp_q.push_back(mk(2'd3, 4'b0111, 3'd3, 10));
    repeat (3) @(negedge Clock);
    Pause = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      chk("no_tick_terminal", Step_pulse, 0);
    end
    Pause = 1'b0;
    wait_pulse("terminal_resume", 4, n);
    chk("terminal_latency", n, 1);

    // PWM on a frozen 0001 pattern.
    run_step(mk(2'd1, 4'b0001, 3'd0, 4));
    Pause = 1'b1;
    @(negedge Clock);
    blev[0] = 4'd4;
    blev[1] = 4'd0;
    blev[2] = 4'hF;
    blev[3] = 4'd1;
    for (int b = 0; b < 4; b++) begin
      Brightness = blev[b];
      repeat (2) @(negedge Clock);
      cnt = 0;
      bad = 0;
      for (int i = 0; i < 32; i++) begin
        @(negedge Clock);
        if (!Leds[0]) cnt++;
        if (Leds[3:1] != 3'b111) bad++;
      end
      chk("pwm_on_cycles", cnt, (blev[b] == 4'hF) ? 32 : 2 * int'(blev[b]));
      chk("pwm_unlit_off", bad, 0);
    end
    Pause = 1'b0;
    Brightness = 4'hF;

    @(negedge Clock);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
